sparse_match_scheduler: RTL
===========================

# sparse_match_scheduler

Sequencer for the sparse-bitmap AND datapath. It accepts one IFM sparsity bitmap and one filter sparsity bitmap and forms their bitwise AND. It then emits the set positions of the AND one per cycle, lowest index first, over a valid/ready handshake. Each emitted position carries the prefix-sum offsets into both compressed operand streams, so the downstream MAC can fetch the matching nonzero IFM and weight values.

## Interface
- BITMAP_W, default `PREFIX_SUM_SIZE: bitmap width in bits; ≥2.
- IDX_W, default $clog2(BITMAP_W): width of position and offset fields.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- load_valid_i  in  1  a new bitmap pair is presented.
- load_ready_o  out  1  the block can accept a pair; high only in IDLE.
- IFM_i  in  BITMAP_W  IFM sparsity bitmap; bit k=1 means element k is nonzero.
- filter_i  in  BITMAP_W  filter sparsity bitmap.
- abort_i  in  1  synchronous abort of the current pair.
- match_valid_o  out  1  a match is presented.
- match_ready_i  in  1  the consumer takes the match.
- match_idx_o  out  IDX_W  bit position of the current match.
- match_ifm_ofs_o  out  IDX_W  count of IFM_i bits set strictly below match_idx_o.
- match_flt_ofs_o  out  IDX_W  count of filter_i bits set strictly below match_idx_o.
- match_last_o  out  1  the current match is the final one for this pair.
- done_o  out  1  one-cycle pulse when a pair is completely processed.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- Registers:
  - A: IFM bitmap.
  - F: filter bitmap.
  - M: remaining-match mask.
  - state: IDLE, EMIT or DONE.
- IDLE:
  - load_ready_o=1.
  - On load_valid_i, capture A←IFM_i, F←filter_i and M←IFM_i & filter_i.
  - If (IFM_i & filter_i)≠0, go to EMIT; otherwise go to DONE.
- EMIT:
  - match_valid_o=1.
  - match_idx_o = lowest set bit of M.
  - match_ifm_ofs_o = popcount(A & ((1<<idx)-1)).
  - match_flt_ofs_o = popcount(F & ((1<<idx)-1)).
  - match_last_o = (M has exactly one bit set).
  - On handshake (match_valid_o & match_ready_i), clear the emitted bit in M.
  - If match_last_o was 1 at the handshake, go to DONE; otherwise stay in EMIT.
- DONE: done_o=1 for exactly this cycle, then go to IDLE. load_ready_o=0 in DONE.
- abort_i:
  - In EMIT or DONE, the next state is IDLE and M←0; no done_o pulse follows.
  - abort_i has priority over a simultaneous handshake. That match counts as not consumed, but the consumer must tolerate it having been sampled.
  - Ignored in IDLE, including when load_valid_i is asserted in the same cycle: the load is accepted.
- The match outputs are combinational from registered A, F and M only. They do not depend on match_ready_i.
- Empty pair (AND=0) produces no matches. DONE is still visited, so done_o pulses.
- Width rules:
  - The offsets never exceed BITMAP_W-1, so IDX_W bits suffice.
  - For M=0, match_idx_o=0, both offsets are 0 and match_last_o=0.

## Timing
- Reset values: state=IDLE and A=F=M=0. Therefore:
  - load_ready_o=1.
  - match_valid_o=0, match_idx_o=0, both offsets 0, match_last_o=0.
  - done_o=0, busy_o=0.
- Load accepted in cycle N: match_valid_o=1 in N+1, or done_o=1 in N+1 for an empty pair.
- Throughput is one match per cycle while match_ready_i=1. A pair with K matches and no stalls:
  - occupies EMIT for K cycles;
  - pulses done_o in the cycle after the last handshake;
  - can accept the next load in the following cycle.
- While match_valid_o=1 and match_ready_i=0, all match outputs hold stable.
- Reset asserted mid-operation immediately forces the reset values (asynchronous). Deassertion resumes in IDLE.
- No combinational path from load_valid_i or match_ready_i to any output.

## Test plan
- BITMAP_W=8. IFM=8'b1011_0110 and filter=8'b1101_0011 with ready held at 1:
  - matches (idx, ifm_ofs, flt_ofs, last) = (1,0,1,0), (4,2,2,0), (7,4,4,1) on three consecutive cycles;
  - done_o follows one cycle after the third;
  - load_ready_o returns one cycle after that.
- Same pair with match_ready_i low for 3 cycles at the second match: idx=4 with offsets 2/2 holds for 4 cycles, then the sequence completes unchanged.
- IFM=8'hF0 and filter=8'h0F: no match_valid_o; done_o in the cycle after the load; load_ready_o high one cycle later.
- IFM=filter=8'hFF: 8 matches idx 0..7 with both offsets equal to idx; match_last_o only at idx 7.
- Abort in the second EMIT cycle of the first scenario, with ready=1 in that cycle:
  - IDLE and load_ready_o=1 next cycle;
  - no done_o pulse;
  - a new load then proceeds normally.
- Assert rst_i asynchronously mid-EMIT: all outputs take their reset values before the next clock edge. After release, a fresh load behaves as in the first scenario.

Source files
------------

// File: rtl/sparse_match_scheduler.sv
// sparse_match_scheduler: emits set bits of IFM&filter lowest-first with prefix-sum offsets into both operand streams.
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 8
`endif
module sparse_match_scheduler #(
  parameter int BITMAP_W = `PREFIX_SUM_SIZE,
  parameter int IDX_W    = $clog2(BITMAP_W)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_valid_i,
  output logic                load_ready_o,
  input  logic [BITMAP_W-1:0] IFM_i,
  input  logic [BITMAP_W-1:0] filter_i,
  input  logic                abort_i,
  output logic                match_valid_o,
  input  logic                match_ready_i,
  output logic [IDX_W-1:0]    match_idx_o,
  output logic [IDX_W-1:0]    match_ifm_ofs_o,
  output logic [IDX_W-1:0]    match_flt_ofs_o,
  output logic                match_last_o,
  output logic                done_o,
  output logic                busy_o
);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  state_t state, state_nx;
  logic [BITMAP_W-1:0] a, f, m, both;
  logic hs, found;
  assign both          = IFM_i & filter_i;
  assign load_ready_o  = state == IDLE;
  assign busy_o        = state != IDLE;
  assign done_o        = state == DONE;
  assign match_valid_o = state == EMIT;
  assign hs            = match_valid_o && match_ready_i;
  assign match_last_o  = |m && ~|(m & (m - 1'b1));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = load_valid_i ? (|both ? EMIT : DONE) : IDLE;
    else if (abort_i || state == DONE) state_nx = IDLE;
    else if (hs && match_last_o) state_nx = DONE;
  end
  // m & (m-1) drops the lowest set bit, i.e. the match just consumed
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      a <= '0;
      f <= '0;
      m <= '0;
    end else if (state == IDLE && load_valid_i) begin
      a <= IFM_i;
      f <= filter_i;
      m <= both;
    end else if (state != IDLE && abort_i) m <= '0;
    else if (hs) m <= m & (m - 1'b1);
  always_comb begin
    match_idx_o     = '0;
    match_ifm_ofs_o = '0;
    match_flt_ofs_o = '0;
    found           = 1'b0;
    for (int i = 0; i < BITMAP_W; i++)
      if (m[i] && !found) begin
        match_idx_o = IDX_W'(i);
        found       = 1'b1;
      end
    for (int i = 0; i < BITMAP_W; i++)
      if (IDX_W'(i) < match_idx_o) begin
        match_ifm_ofs_o = match_ifm_ofs_o + IDX_W'(a[i]);
        match_flt_ofs_o = match_flt_ofs_o + IDX_W'(f[i]);
      end
  end
endmodule
